// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler that owns the select of a shared 16:1 single-bit mux and
// streams the grantee's bit onto a registered output in bursts of up to MAX_BURST.
module mux16_rr_sched #(
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] in,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        q,
    output logic        valid,
    output logic [3:0]  owner,
    output logic        last
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [3:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       winner;
    logic [3:0]       idx;

    // Scan from the farthest offset down so the closest requester to ptr is written last.
    // NOTE: every always_comb output gets a default first; otherwise a latch is inferred.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr + 4'(k);
            if (req[idx]) winner = idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            sel   <= '0;
            grant <= '0;
            q     <= 1'b0;
            valid <= 1'b0;
            owner <= '0;
            last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    last  <= 1'b0;
                    if (|req) begin
                        state <= GRANT;
                        sel   <= winner;
                        grant <= 16'(1) << winner;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (req[sel]) begin
                        q     <= in[sel];
                        owner <= sel;
                        valid <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            last  <= 1'b1;
                            state <= IDLE;
                            grant <= '0;
                            ptr   <= sel + 4'd1;
                        end else begin
                            cnt  <= cnt + CNT_W'(1);
                            last <= 1'b0;
                        end
                    end else begin
                        // Requester let go: end the burst without a transfer or a last flag.
                        valid <= 1'b0;
                        last  <= 1'b0;
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= sel + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched (MAX_BURST = 8): inputs change and outputs are
// sampled on the falling edge, half a cycle away from the active rising edge.
module tb_mux16_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] in_bits;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        q;
    logic        valid;
    logic [3:0]  owner;
    logic        last;

    int n_tests = 0;
    int n_fail  = 0;

    mux16_rr_sched #(.MAX_BURST(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .in    (in_bits),
        .sel   (sel),
        .grant (grant),
        .q     (q),
        .valid (valid),
        .owner (owner),
        .last  (last)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n   = 1'b0;
        req     = '0;
        in_bits = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        in_bits = '0;
        #3;
        n_tests++;
        if (sel !== 4'd0 || grant !== 16'h0 || q !== 1'b0 || valid !== 1'b0 ||
            owner !== 4'd0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: sel=%0d grant=%h q=%b valid=%b owner=%0d last=%b, want all 0",
                     sel, grant, q, valid, owner, last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (grant !== 16'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: grant=%h valid=%b, want grant=0000 valid=0", grant, valid);
        end
    endtask

    task automatic test_single();
        logic        exp_last;
        logic [15:0] exp_grant;
        apply_reset();
        req     = 16'h0020;
        in_bits = 16'h0020;
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd5 || grant !== 16'h0020 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: sel=%0d grant=%h valid=%b, want sel=5 grant=0020 valid=0",
                     sel, grant, valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_last  = (i == 7);
            exp_grant = (i == 7) ? 16'h0000 : 16'h0020;
            n_tests++;
            if (valid !== 1'b1 || q !== 1'b1 || owner !== 4'd5 || last !== exp_last ||
                grant !== exp_grant) begin
                n_fail++;
                $display("FAIL single_xfer%0d: valid=%b q=%b owner=%0d last=%b grant=%h, want 1 1 5 %b %h",
                         i, valid, q, owner, last, grant, exp_last, exp_grant);
            end
        end
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd5 || grant !== 16'h0020 || valid !== 1'b0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_regrant: sel=%0d grant=%h valid=%b last=%b, want 5 0020 0 0",
                     sel, grant, valid, last);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_all();
        logic [3:0] exp_sel;
        apply_reset();
        req     = 16'hFFFF;
        in_bits = 16'hA5C3;
        for (int g = 0; g < 17; g++) begin
            exp_sel = 4'(g);
            @(negedge clk);
            n_tests++;
            if (sel !== exp_sel || grant !== (16'(1) << exp_sel) || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL all_grant%0d: sel=%0d grant=%h valid=%b, want sel=%0d grant=%h valid=0",
                         g, sel, grant, valid, exp_sel, 16'(1) << exp_sel);
            end
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                n_tests++;
                if (valid !== 1'b1 || owner !== exp_sel || q !== in_bits[exp_sel] ||
                    last !== (i == 7) || (i == 7 && grant !== 16'h0)) begin
                    n_fail++;
                    $display("FAIL all_xfer%0d_%0d: valid=%b owner=%0d q=%b last=%b grant=%h, want 1 %0d %b %b",
                             g, i, valid, owner, q, last, grant, exp_sel, in_bits[exp_sel], i == 7);
                end
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        apply_reset();
        req     = 16'h8000;
        in_bits = 16'h8000;
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd15 || grant !== 16'h8000) begin
            n_fail++;
            $display("FAIL wrap_first: sel=%0d grant=%h, want sel=15 grant=8000", sel, grant);
        end
        for (int i = 0; i < 8; i++) @(negedge clk);
        req     = 16'h4001;
        in_bits = 16'h0001;
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd0 || grant !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap_to_zero: sel=%0d grant=%h, want sel=0 grant=0001", sel, grant);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (valid !== 1'b1 || owner !== 4'd0 || q !== 1'b1 || last !== (i == 7)) begin
                n_fail++;
                $display("FAIL wrap_xfer%0d: valid=%b owner=%0d q=%b last=%b, want 1 0 1 %b",
                         i, valid, owner, q, last, i == 7);
            end
        end
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd14 || grant !== 16'h4000) begin
            n_fail++;
            $display("FAIL wrap_next: sel=%0d grant=%h, want sel=14 grant=4000", sel, grant);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_early_release();
        apply_reset();
        req     = 16'h0008;
        in_bits = 16'h0008;
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd3 || grant !== 16'h0008) begin
            n_fail++;
            $display("FAIL early_grant: sel=%0d grant=%h, want sel=3 grant=0008", sel, grant);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (valid !== 1'b1 || owner !== 4'd3 || q !== 1'b1 || last !== 1'b0) begin
                n_fail++;
                $display("FAIL early_xfer%0d: valid=%b owner=%0d q=%b last=%b, want 1 3 1 0",
                         i, valid, owner, q, last);
            end
        end
        req = '0;
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0 || grant !== 16'h0 || last !== 1'b0 || sel !== 4'd3) begin
            n_fail++;
            $display("FAIL early_release: valid=%b grant=%h last=%b sel=%0d, want 0 0000 0 3",
                     valid, grant, last, sel);
        end
        // Requesters 3 and 4 compete; the advanced pointer must favour 4.
        req = 16'h0018;
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd4 || grant !== 16'h0010) begin
            n_fail++;
            $display("FAIL early_ptr: sel=%0d grant=%h, want sel=4 grant=0010", sel, grant);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_data();
        logic [7:0]  pattern = 8'b0100_1101;
        logic [15:0] noise;
        apply_reset();
        req     = 16'h0200;
        in_bits = 16'h0000;
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd9 || grant !== 16'h0200) begin
            n_fail++;
            $display("FAIL data_grant: sel=%0d grant=%h, want sel=9 grant=0200", sel, grant);
        end
        for (int i = 0; i < 8; i++) begin
            noise      = 16'($urandom);
            noise[9]   = pattern[i];
            in_bits    = noise;
            @(negedge clk);
            n_tests++;
            if (valid !== 1'b1 || owner !== 4'd9 || q !== pattern[i] || last !== (i == 7)) begin
                n_fail++;
                $display("FAIL data_bit%0d: valid=%b owner=%0d q=%b last=%b, want 1 9 %b %b",
                         i, valid, owner, q, last, pattern[i], i == 7);
            end
        end
        // q must hold its final value once valid drops.
        in_bits = 16'hFFFF;
        req     = '0;
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0 || q !== pattern[7]) begin
            n_fail++;
            $display("FAIL data_hold: valid=%b q=%b, want valid=0 q=%b", valid, q, pattern[7]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req     = 16'h0100;
        in_bits = 16'hFFFF;
        repeat (5) @(negedge clk);
        n_tests++;
        if (valid !== 1'b1 || owner !== 4'd8 || grant !== 16'h0100) begin
            n_fail++;
            $display("FAIL mid_before: valid=%b owner=%0d grant=%h, want 1 8 0100", valid, owner, grant);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (sel !== 4'd0 || grant !== 16'h0 || q !== 1'b0 || valid !== 1'b0 ||
            owner !== 4'd0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_clear: sel=%0d grant=%h q=%b valid=%b owner=%0d last=%b, want all 0",
                     sel, grant, q, valid, owner, last);
        end
        req = 16'h8001;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sel !== 4'd0 || grant !== 16'h0001) begin
            n_fail++;
            $display("FAIL mid_restart: sel=%0d grant=%h, want sel=0 grant=0001", sel, grant);
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_wrap();
        test_early_release();
        test_data();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
